pool_window_buffer: RTL

POOL_WINDOW_BUFFER -- requirements
Module: pool_window_buffer

---
 rtl/pool_window_buffer.sv | 104 ++++++++++
 1 files changed

// File: rtl/pool_window_buffer.sv
// Streams pixels row-major and emits each non-overlapping 2x2 window one clock
// after its bottom-right pixel is accepted. Even rows are parked in a line buffer.
module pool_window_buffer #(
  parameter int unsigned BITWIDTH = 8,
  parameter int unsigned WIDTH    = 28,
  parameter int unsigned HEIGHT   = 28
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic signed [BITWIDTH-1:0] in_data,
  output logic                       out_valid,
  output logic signed [BITWIDTH-1:0] out_a,
  output logic signed [BITWIDTH-1:0] out_b,
  output logic signed [BITWIDTH-1:0] out_c,
  output logic signed [BITWIDTH-1:0] out_d,
  output logic                       out_last
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned RW = $clog2(HEIGHT);

  typedef enum logic [0:0] {StEvenRow, StOddRow} state_e;

  state_e                       state_q;
  logic [CW-1:0]                col_q;
  logic [RW-1:0]                row_q;
  logic signed [BITWIDTH-1:0]   hold_q;
  logic signed [BITWIDTH-1:0]   line_q [WIDTH];
  logic                         out_valid_q;
  logic                         out_last_q;
  logic signed [BITWIDTH-1:0]   out_a_q;
  logic signed [BITWIDTH-1:0]   out_b_q;
  logic signed [BITWIDTH-1:0]   out_c_q;
  logic signed [BITWIDTH-1:0]   out_d_q;

  logic          col_last;
  logic          row_last;
  logic [CW-1:0] col_prev;

  assign col_last = (col_q == CW'(WIDTH - 1));
  assign row_last = (row_q == RW'(HEIGHT - 1));
  assign col_prev = col_q - CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StEvenRow;
      col_q       <= '0;
      row_q       <= '0;
      hold_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_c_q     <= '0;
      out_d_q     <= '0;
    end else begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      if (in_valid) begin
        if (col_last) begin
          col_q <= '0;
          row_q <= row_last ? '0 : row_q + RW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
        unique case (state_q)
          StEvenRow: begin
            if (col_last) state_q <= StOddRow;
          end
          StOddRow: begin
            if (!col_q[0]) begin
              hold_q <= in_data;
            end else begin
              out_a_q     <= line_q[col_prev];
              out_b_q     <= line_q[col_q];
              out_c_q     <= hold_q;
              out_d_q     <= in_data;
              out_valid_q <= 1'b1;
              out_last_q  <= row_last && col_last;
            end
            if (col_last) state_q <= StEvenRow;
          end
          default: state_q <= StEvenRow;
        endcase
      end
    end
  end

  // No reset needed: every entry is rewritten in the even row before it is read.
  always_ff @(posedge clk) begin
    if (!rst && in_valid && (state_q == StEvenRow)) begin
      line_q[col_q] <= in_data;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_c     = out_c_q;
  assign out_d     = out_d_q;

endmodule
